// File: rtl/axi_stream_width_down_pkg.sv
// Shared stream helpers: mod-field sizing and the chunk-count rule used by the
// width down-sizer and its matching up-sizer.
package axi_stream_width_down_pkg;

  function automatic int unsigned mod_bits(input int unsigned byts);
    return (byts > 1) ? $clog2(byts) : 1;
  endfunction

  // Number of narrow chunks (lim+1) a wide beat expands into.
  function automatic int unsigned stream_chunks(input int unsigned mod,
                                                input logic        eop,
                                                input int unsigned in_byts,
                                                input int unsigned out_byts);
    if (!eop || mod == 0) return in_byts / out_byts;
    return (mod + out_byts - 1) / out_byts;
  endfunction

endpackage

// File: rtl/axi_stream_width_down_if.sv
// Packetised AXI-stream bundle with sop/eop framing, byte-count mod and sideband ctl.
interface if_axi_stream
  import axi_stream_width_down_pkg::*;
#(
  parameter int unsigned DAT_BYTS = 8,
  parameter int unsigned CTL_BITS = 8
);
  localparam int unsigned MOD_W = mod_bits(DAT_BYTS);

  logic [DAT_BYTS*8-1:0] dat;
  logic                  val;
  logic                  sop;
  logic                  eop;
  logic                  err;
  logic [MOD_W-1:0]      mod;
  logic [CTL_BITS-1:0]   ctl;
  logic                  rdy;

  modport master (output dat, val, sop, eop, err, mod, ctl, input rdy);
  modport slave  (input dat, val, sop, eop, err, mod, ctl, output rdy);

endinterface

// File: rtl/axi_stream_width_down.sv
// Splits each wide stream beat into IN_BYTS/OUT_BYTS narrow chunks, lowest bytes
// first, keeping packet framing and sideband ctl; no bubble between beats.
module axi_stream_width_down
  import axi_stream_width_down_pkg::*;
#(
  parameter int unsigned IN_BYTS  = 64,
  parameter int unsigned OUT_BYTS = 8,
  parameter int unsigned CTL_BITS = 8
)(
  input  logic          i_clk,
  input  logic          i_rst_n,
  if_axi_stream.slave   i_axi,
  if_axi_stream.master  o_axi
);

  localparam int unsigned R         = (OUT_BYTS == 0) ? 1 : IN_BYTS / OUT_BYTS;
  localparam int unsigned IN_W      = IN_BYTS * 8;
  localparam int unsigned OUT_W     = OUT_BYTS * 8;
  localparam int unsigned IN_MOD_W  = mod_bits(IN_BYTS);
  localparam int unsigned OUT_MOD_W = mod_bits(OUT_BYTS);
  localparam int unsigned IDX_W     = (R > 1) ? $clog2(R) : 1;

  generate
    if (OUT_BYTS == 0) begin : g_bad_out
      $fatal(1, "axi_stream_width_down: OUT_BYTS must be >= 1");
    end else if (IN_BYTS % OUT_BYTS != 0) begin : g_bad_ratio
      $fatal(1, "axi_stream_width_down: IN_BYTS must be a multiple of OUT_BYTS");
    end
  endgenerate

  logic                full_q, full_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    lim_q, lim_d;
  logic [IN_W-1:0]     dat_q, dat_d;
  logic                sop_q, sop_d;
  logic                eop_q, eop_d;
  logic                err_q, err_d;
  logic [IN_MOD_W-1:0] mod_q, mod_d;
  logic [CTL_BITS-1:0] ctl_q, ctl_d;

  logic                last;
  logic                adv;
  logic                in_rdy;
  logic                load;

  logic [OUT_W-1:0]     out_dat;
  logic                 out_sop;
  logic                 out_eop;
  logic                 out_err;
  logic [OUT_MOD_W-1:0] out_mod;

  // Ready looks through the last chunk so a waiting beat reloads without a gap.
  assign last   = (idx_q == lim_q);
  assign adv    = full_q && o_axi.rdy;
  assign in_rdy = !full_q || (adv && last);
  assign load   = i_axi.val && in_rdy;

  always_comb begin
    full_d = full_q;
    idx_d  = idx_q;
    lim_d  = lim_q;
    dat_d  = dat_q;
    sop_d  = sop_q;
    eop_d  = eop_q;
    err_d  = err_q;
    mod_d  = mod_q;
    ctl_d  = ctl_q;
    if (load) begin
      full_d = 1'b1;
      idx_d  = '0;
      lim_d  = IDX_W'(stream_chunks(32'(i_axi.mod), i_axi.eop, IN_BYTS, OUT_BYTS) - 32'd1);
      dat_d  = i_axi.dat;
      sop_d  = i_axi.sop;
      eop_d  = i_axi.eop;
      err_d  = i_axi.err;
      mod_d  = i_axi.mod;
      ctl_d  = i_axi.ctl;
    end else if (adv && last) begin
      full_d = 1'b0;
      idx_d  = '0;
    end else if (adv) begin
      idx_d  = idx_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full_q <= 1'b0;
      idx_q  <= '0;
      lim_q  <= '0;
      dat_q  <= '0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
      err_q  <= 1'b0;
      mod_q  <= '0;
      ctl_q  <= '0;
    end else begin
      full_q <= full_d;
      idx_q  <= idx_d;
      lim_q  <= lim_d;
      dat_q  <= dat_d;
      sop_q  <= sop_d;
      eop_q  <= eop_d;
      err_q  <= err_d;
      mod_q  <= mod_d;
      ctl_q  <= ctl_d;
    end
  end

  always_comb begin
    out_dat = '0;
    for (int unsigned k = 0; k < R; k++) begin
      if (idx_q == IDX_W'(k)) out_dat = dat_q[k*OUT_W +: OUT_W];
    end
    out_sop = sop_q && (idx_q == '0);
    out_eop = eop_q && last;
    out_err = err_q && out_eop;
    out_mod = out_eop ? OUT_MOD_W'(32'(mod_q) % OUT_BYTS) : '0;
  end

  assign i_axi.rdy = in_rdy;
  assign o_axi.val = full_q;
  assign o_axi.dat = out_dat;
  assign o_axi.sop = out_sop;
  assign o_axi.eop = out_eop;
  assign o_axi.err = out_err;
  assign o_axi.mod = out_mod;
  assign o_axi.ctl = ctl_q;

endmodule

// File: tb/tb_axi_stream_width_down.sv
// Scoreboard bench: a 64->8 byte instance and an 8->8 byte (R=1) instance.
module tb_axi_stream_width_down;

  typedef struct {
    logic [63:0] dat;
    logic        sop;
    logic        eop;
    logic        err;
    logic        last;
    logic [2:0]  mod;
    logic [7:0]  ctl;
  } chunk_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_axi_stream #(.DAT_BYTS(64), .CTL_BITS(8)) in0 ();
  if_axi_stream #(.DAT_BYTS(8),  .CTL_BITS(8)) out0 ();
  if_axi_stream #(.DAT_BYTS(8),  .CTL_BITS(8)) in1 ();
  if_axi_stream #(.DAT_BYTS(8),  .CTL_BITS(8)) out1 ();

  axi_stream_width_down #(.IN_BYTS(64), .OUT_BYTS(8), .CTL_BITS(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_axi(in0), .o_axi(out0));

  axi_stream_width_down #(.IN_BYTS(8), .OUT_BYTS(8), .CTL_BITS(8)) dut_r1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_axi(in1), .o_axi(out1));

  int     n_checks = 0;
  int     n_fail   = 0;
  chunk_t q0[$];
  chunk_t q1[$];
  int     xfer0 = 0;
  int     xfer1 = 0;
  logic   rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor + scoreboard for the 64->8 instance.
  always @(negedge clk) begin : mon0
    chunk_t c;
    int     n;
    if (rst_n) begin
      check("o0_val", 64'(out0.val), 64'(q0.size() != 0));
      check("i0_rdy", 64'(in0.rdy), 64'((q0.size() == 0) || (out0.rdy && q0[0].last)));
      if (out0.val && q0.size() != 0) begin
        c = q0[0];
        check("o0_dat", out0.dat, c.dat);
        check("o0_frm", 64'({out0.sop, out0.eop, out0.err, out0.mod, out0.ctl}),
                        64'({c.sop, c.eop, c.err, c.mod, c.ctl}));
        if (out0.rdy) begin
          void'(q0.pop_front());
          xfer0++;
        end
      end
      if (in0.val && in0.rdy) begin
        n = (in0.eop && in0.mod != 0) ? (int'(in0.mod) + 7) / 8 : 8;
        for (int k = 0; k < n; k++) begin
          c.dat  = in0.dat[k*64 +: 64];
          c.last = (k == n - 1);
          c.sop  = in0.sop && (k == 0);
          c.eop  = in0.eop && c.last;
          c.err  = in0.err && c.eop;
          c.mod  = c.eop ? 3'(in0.mod % 8) : 3'd0;
          c.ctl  = in0.ctl;
          q0.push_back(c);
        end
      end
    end
  end

  // Monitor + scoreboard for the R=1 instance.
  always @(negedge clk) begin : mon1
    chunk_t c;
    if (rst_n) begin
      check("o1_val", 64'(out1.val), 64'(q1.size() != 0));
      check("i1_rdy", 64'(in1.rdy), 64'((q1.size() == 0) || out1.rdy));
      if (out1.val && q1.size() != 0) begin
        c = q1[0];
        check("o1_dat", out1.dat, c.dat);
        check("o1_frm", 64'({out1.sop, out1.eop, out1.err, out1.mod, out1.ctl}),
                        64'({c.sop, c.eop, c.err, c.mod, c.ctl}));
        if (out1.rdy) begin
          void'(q1.pop_front());
          xfer1++;
        end
      end
      if (in1.val && in1.rdy) begin
        c.dat  = in1.dat;
        c.last = 1'b1;
        c.sop  = in1.sop;
        c.eop  = in1.eop;
        c.err  = in1.err && in1.eop;
        c.mod  = in1.eop ? in1.mod : 3'd0;
        c.ctl  = in1.ctl;
        q1.push_back(c);
      end
    end
  end

  initial begin
    out0.rdy = 1'b1;
    out1.rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out0.rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send0(input logic [511:0] d, input logic s, input logic e, input logic er,
                       input logic [5:0] m, input logic [7:0] ct);
    int cyc;
    in0.dat = d; in0.sop = s; in0.eop = e; in0.err = er; in0.mod = m; in0.ctl = ct;
    in0.val = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!in0.rdy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    if (!in0.rdy) check("i0_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in0.val = 1'b0;
  endtask

  task automatic send1(input logic [63:0] d, input logic s, input logic e, input logic er,
                       input logic [2:0] m, input logic [7:0] ct);
    int cyc;
    in1.dat = d; in1.sop = s; in1.eop = e; in1.err = er; in1.mod = m; in1.ctl = ct;
    in1.val = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!in1.rdy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    if (!in1.rdy) check("i1_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in1.val = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((q0.size() != 0 || q1.size() != 0 || out0.val || out1.val) && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 5000) check("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_val0"}, 64'({out0.val, out1.val}), 64'd0);
    check({tag, "_dat0"}, out0.dat, 64'd0);
    check({tag, "_frm0"}, 64'({out0.sop, out0.eop, out0.err, out0.mod, out0.ctl}), 64'd0);
    check({tag, "_rdy0"}, 64'(in0.rdy), 64'd1);
  endtask

  initial begin : watchdog
    #900000;
    check("watchdog", 64'd0, 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [511:0] d;
    int           base;
    int           nb;
    int           cyc;

    in0.val = 1'b0; in0.dat = '0; in0.sop = 1'b0; in0.eop = 1'b0;
    in0.err = 1'b0; in0.mod = '0; in0.ctl = '0;
    in1.val = 1'b0; in1.dat = '0; in1.sop = 1'b0; in1.eop = 1'b0;
    in1.err = 1'b0; in1.mod = '0; in1.ctl = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    #1;
    rst_n = 1'b1;

    // Single full beat: bytes 0x00..0x3F -> 8 chunks.
    for (int i = 0; i < 64; i++) d[i*8 +: 8] = 8'(i);
    base = xfer0;
    send0(d, 1'b1, 1'b1, 1'b0, 6'd0, 8'hA5);
    drain();
    check("t1_chunks", 64'(xfer0 - base), 64'd8);

    // Short eop beats.
    base = xfer0;
    send0(d, 1'b1, 1'b1, 1'b1, 6'd20, 8'h3C);
    drain();
    check("t2_mod20_chunks", 64'(xfer0 - base), 64'd3);
    base = xfer0;
    send0(d, 1'b1, 1'b1, 1'b0, 6'd16, 8'h11);
    drain();
    check("t2_mod16_chunks", 64'(xfer0 - base), 64'd2);
    base = xfer0;
    send0(d, 1'b1, 1'b1, 1'b0, 6'd1, 8'h22);
    drain();
    check("t2_mod1_chunks", 64'(xfer0 - base), 64'd1);

    // Back-to-back 3-beat packet under rdy=1.
    base = xfer0;
    for (int b = 0; b < 3; b++) begin
      for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
      send0(d, 1'(b == 0), 1'(b == 2), 1'b0, 6'd0, 8'(b));
    end
    drain();
    check("t3_chunks", 64'(xfer0 - base), 64'd24);

    // Random packets with random output back-pressure.
    rand_rdy = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
        send0(d, 1'(b == 0), 1'(b == nb - 1), 1'($urandom_range(0, 3) == 0),
              6'($urandom), 8'($urandom));
        if ($urandom_range(0, 7) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    drain();

    // Reset in the middle of a beat, once chunk 3 has gone out.
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
    base = xfer0;
    send0(d, 1'b1, 1'b0, 1'b0, 6'd0, 8'h77);
    cyc = 0;
    while ((xfer0 - base) < 3 && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    check("t5_pre_chunks", 64'(xfer0 - base), 64'd3);
    #2;
    rst_n = 1'b0;
    q0.delete();
    #1;
    check_reset_outputs("t5_rst");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
    base = xfer0;
    send0(d, 1'b1, 1'b1, 1'b0, 6'd0, 8'h99);
    drain();
    check("t5_post_chunks", 64'(xfer0 - base), 64'd8);

    // R=1 instance: back-to-back beats, framing passed straight through.
    base = xfer1;
    for (int b = 0; b < 12; b++) begin
      send1({$urandom, $urandom}, 1'(b % 3 == 0), 1'(b % 3 == 2), 1'(b % 4 == 2),
            (b % 3 == 2) ? 3'($urandom) : 3'd0, 8'($urandom));
    end
    drain();
    check("t6_beats", 64'(xfer1 - base), 64'd12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
